muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv.sv | 131 +++++++++++++
 tb/tb_muldiv.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared MIPS definitions for the EX stage: instruction field positions,
// SPECIAL-opcode function codes for the HI/LO unit, and multiply/divide latencies.
// No ports; imported by muldiv.
package muldiv_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  // Encoded to match func[1:0] of the four multiply/divide opcodes.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_kind_t;

  function automatic logic [5:0] ir_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [5:0] ir_func(input logic [31:0] ir);
    return ir[5:0];
  endfunction

endpackage

// File: rtl/muldiv.sv
// MIPS HI/LO multiply/divide unit: mult/multu take 5 cycles, div/divu 10, mt*/mf* act at once.
// Ports: clk, reset (sync, active-high); numa/numb operands and ir_e instruction from EX;
//        start (comb), busy (registered) for the hazard unit; hilo_out carries HI/LO for mfhi/mflo.
module muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  input  logic [31:0] ir_e,
  output logic        start,
  output logic        busy,
  output logic [31:0] hilo_out
);

  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] opa;
  logic [31:0] opb;
  md_kind_t    kind;
  logic [3:0]  cnt;

  logic [5:0]  func;
  logic        is_special;
  logic        is_md;
  logic        is_mthi;
  logic        is_mtlo;
  logic        is_mfhi;
  logic        is_mflo;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Only op and func take part in decoding; the register fields are ignored.
  logic [19:0] ir_unused;
  assign ir_unused = ir_e[25:6];

  always_comb begin
    func       = ir_func(ir_e);
    is_special = (ir_op(ir_e) == OP_SPECIAL);
    is_md      = is_special && (func == F_MULT || func == F_MULTU ||
                                func == F_DIV  || func == F_DIVU);
    is_mthi    = is_special && (func == F_MTHI);
    is_mtlo    = is_special && (func == F_MTLO);
    is_mfhi    = is_special && (func == F_MFHI);
    is_mflo    = is_special && (func == F_MFLO);
  end

  assign start = is_md && !busy;

  always_comb begin
    hilo_out = 32'h0;
    if (is_mfhi)      hilo_out = hi;
    else if (is_mflo) hilo_out = lo;
  end

  // Result is a pure function of the latched operands; the counter only
  // models latency, so the value is simply captured when it reaches zero.
  always_comb begin
    prod_s = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
    prod_u = {32'h0, opa} * {32'h0, opb};
    quo_s  = $signed(opa) / $signed(opb);
    rem_s  = $signed(opa) % $signed(opb);
    res_hi = 32'h0;
    res_lo = 32'h0;
    case (kind)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (opb == 32'h0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = opa;
        end else if (opa == 32'h8000_0000 && opb == 32'hFFFF_FFFF) begin
          // Quotient does not fit; wraps to the dividend, remainder zero.
          res_lo = 32'h8000_0000;
          res_hi = 32'h0;
        end else begin
          res_lo = quo_s;
          res_hi = rem_s;
        end
      end
      MD_DIVU: begin
        if (opb == 32'h0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = opa;
        end else begin
          res_lo = opa / opb;
          res_hi = opa % opb;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= 32'h0;
      lo   <= 32'h0;
      opa  <= 32'h0;
      opb  <= 32'h0;
      kind <= MD_MULT;
      cnt  <= 4'd0;
      busy <= 1'b0;
    end else if (busy) begin
      // Instructions arriving while busy are dropped; the pipeline is stalled.
      if (cnt == 4'd0) begin
        hi   <= res_hi;
        lo   <= res_lo;
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      if (start) begin
        opa  <= numa;
        opb  <= numb;
        kind <= md_kind_t'(func[1:0]);
        cnt  <= func[1] ? 4'(DIV_CYC - 1) : 4'(MULT_CYC - 1);
        busy <= 1'b1;
      end
      if (is_mthi) hi <= numa;
      if (is_mtlo) lo <= numa;
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Randomized self-checking bench for muldiv against an arithmetic HI/LO model.
module tb_muldiv;

  localparam logic [5:0] T_MFHI  = 6'b010000;
  localparam logic [5:0] T_MTHI  = 6'b010001;
  localparam logic [5:0] T_MFLO  = 6'b010010;
  localparam logic [5:0] T_MTLO  = 6'b010011;
  localparam logic [5:0] T_MULT  = 6'b011000;
  localparam logic [5:0] T_MULTU = 6'b011001;
  localparam logic [5:0] T_DIV   = 6'b011010;
  localparam logic [5:0] T_DIVU  = 6'b011011;
  localparam logic [31:0] NOP    = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] numa;
  logic [31:0] numb;
  logic [31:0] ir_e;
  logic        start;
  logic        busy;
  logic [31:0] hilo_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  muldiv dut (
    .clk      (clk),
    .reset    (reset),
    .numa     (numa),
    .numb     (numb),
    .ir_e     (ir_e),
    .start    (start),
    .busy     (busy),
    .hilo_out (hilo_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    // Random register fields must not affect decoding.
    return {6'b000000, 20'($urandom), f};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one multiply/divide, straight from the ISA rules.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = a;
    sb = b;
    h = 32'h0;
    l = 32'h0;
    if (f == T_MULT) begin
      sp = longint'(sa) * longint'(sb);
      {h, l} = sp;
    end else if (f == T_MULTU) begin
      up = longint'({32'h0, a}) * longint'({32'h0, b});
      {h, l} = up;
    end else if (b == 32'h0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else if (f == T_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        l = 32'h8000_0000;
        h = 32'h0;
      end else begin
        l = sa / sb;
        h = sa % sb;
      end
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  task automatic read_hilo(input string tag);
    @(negedge clk);
    ir_e = rtype(T_MFHI);
    #1 check({tag, ".hi"}, hilo_out, hi_m);
    ir_e = rtype(T_MFLO);
    #1 check({tag, ".lo"}, hilo_out, lo_m);
    ir_e = NOP;
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] v);
    @(negedge clk);
    ir_e = rtype(f);
    numa = v;
    if (f == T_MTHI) hi_m = v;
    else             lo_m = v;
    @(negedge clk);
    ir_e = NOP;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, cycles;
    model(f, a, b, eh, el);
    n = (f == T_DIV || f == T_DIVU) ? 10 : 5;
    @(negedge clk);
    ir_e = rtype(f);
    numa = a;
    numb = b;
    #1 check({tag, ".start"}, 32'(start), 32'd1);
    @(negedge clk);
    cycles = 0;
    while (busy === 1'b1 && cycles < 30) begin
      cycles++;
      ir_e = NOP;
      numa = $urandom;
      numb = $urandom;
      if (cycles == 2) begin
        // Old HI visible during busy; new ops and moves must be ignored.
        ir_e = rtype(T_MFHI);
        #1 check({tag, ".mfhi_busy"}, hilo_out, hi_m);
        ir_e = rtype(T_MULT);
        #1 check({tag, ".start_busy"}, 32'(start), 32'd0);
        ir_e = rtype(T_MTHI);
        numa = 32'hDEAD_BEEF;
      end else if (cycles == 3) begin
        ir_e = rtype(T_MTLO);
      end
      @(negedge clk);
    end
    check({tag, ".busy_len"}, 32'(cycles), 32'(n));
    ir_e = NOP;
    hi_m = eh;
    lo_m = el;
    // Result must already be visible in the cycle busy falls.
    ir_e = rtype(T_MFHI);
    #1 check({tag, ".hi_now"}, hilo_out, hi_m);
    ir_e = NOP;
    read_hilo(tag);
  endtask

  initial begin
    logic [5:0] ops[4];
    ops[0] = T_MULT; ops[1] = T_MULTU; ops[2] = T_DIV; ops[3] = T_DIVU;
    reset = 1'b1;
    numa  = 32'h0;
    numb  = 32'h0;
    ir_e  = NOP;
    hi_m  = 32'h0;
    lo_m  = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("rst.busy", 32'(busy), 32'd0);
    check("rst.start", 32'(start), 32'd0);
    check("rst.out_nop", hilo_out, 32'h0);
    read_hilo("rst");

    run_op("mult",  T_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
    run_op("multu", T_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("div",   T_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu0", T_DIVU,  32'h0000_0007, 32'h0000_0000);
    run_op("div0",  T_DIV,   32'h8765_4321, 32'h0000_0000);
    run_op("divov", T_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

    move_to(T_MTHI, 32'h1234_5678);
    move_to(T_MTLO, 32'h9ABC_DEF0);
    read_hilo("mt");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = b >> $urandom_range(31, 16);
      if (i % 7 == 3) b = 32'h0;
      if (i % 4 == 2) move_to(T_MTHI, $urandom);
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(3, 0)], a, b);
    end

    // Abort mid-operation: reset at busy cycle 3 must clear state and block the write.
    @(negedge clk);
    ir_e = rtype(T_MULT);
    numa = 32'h0000_1234;
    numb = 32'h0000_5678;
    repeat (3) begin
      @(negedge clk);
      ir_e = NOP;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort.busy", 32'(busy), 32'd0);
    hi_m = 32'h0;
    lo_m = 32'h0;
    read_hilo("abort");
    repeat (12) @(negedge clk);
    check("abort.busy_late", 32'(busy), 32'd0);
    read_hilo("abort_late");

    // Reset wins over a same-cycle mthi/mtlo and start.
    move_to(T_MTLO, 32'h0F0F_0F0F);
    @(negedge clk);
    reset = 1'b1;
    ir_e  = rtype(T_MTHI);
    numa  = 32'h5555_AAAA;
    @(negedge clk);
    ir_e  = rtype(T_DIV);
    @(negedge clk);
    reset = 1'b0;
    ir_e  = NOP;
    #1 check("rstprio.busy", 32'(busy), 32'd0);
    hi_m = 32'h0;
    lo_m = 32'h0;
    read_hilo("rstprio");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
